reg_dump_sequencer: RTL and testbench

Post-halt debug sequencer that walks the register bank through its debug read port and streams every register to the debug UART transmitter as bytes. It sits between the debug unit and the decode stage. It drives the decode stage's debug select and debug address inputs (`i_br_enable`, `i_br_addr`). It reads the data returned on `o_data_reg_debug_unit` and hands bytes to the TX side with a valid/ready handshake.

---
 rtl/reg_dump_sequencer.sv | 112 +++++++++++
 tb/tb_reg_dump_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// Post-halt register dump: walks the register bank via its debug read port and streams each word out as bytes, LSB first.
// Latency: first byte offered 3 cycles after i_start; BPW+3 cycles per register when the TX side never stalls.
// Backpressure: i_tx_ready low freezes the offered byte and valid; every output is decoded from registered state.
module reg_dump_sequencer #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_reg_data,
    input  logic               i_tx_ready,
    output logic               o_br_enable,
    output logic [NB_REG-1:0]  o_br_addr,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BPW    = NB_DATA / NB_BYTE;
    localparam int NB_IDX = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX  = NB_IDX'(BPW - 1);
    localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LATCH,
        SEND,
        NEXT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NB_REG-1:0]   addr;
    logic [NB_DATA-1:0]  word;
    logic [NB_IDX-1:0]   byte_idx;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = SELECT;
            SELECT:  state_nxt = LATCH;
            LATCH:   state_nxt = SEND;
            SEND:    if (i_tx_ready && (byte_idx == LAST_IDX)) state_nxt = NEXT;
            NEXT:    state_nxt = (addr == LAST_ADDR) ? DONE : SELECT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_abort) begin
            state_nxt = IDLE;
        end
    end

    // The word register shifts right on each accepted byte, so the offered byte is always its low slice.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            addr     <= '0;
            word     <= '0;
            byte_idx <= '0;
        end else if (i_abort) begin
            addr     <= '0;
            word     <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                LATCH: begin
                    word     <= i_reg_data;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        word     <= word >> NB_BYTE;
                        byte_idx <= byte_idx + NB_IDX'(1);
                    end
                end
                NEXT: begin
                    if (addr != LAST_ADDR) begin
                        addr <= addr + NB_REG'(1);
                    end
                end
                DONE: begin
                    addr     <= '0;
                    word     <= '0;
                    byte_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_br_enable = (state == SELECT) || (state == LATCH) || (state == SEND) || (state == NEXT);
    assign o_br_addr   = addr;
    assign o_tx_valid  = (state == SEND);
    assign o_tx_data   = (state == SEND) ? word[NB_BYTE-1:0] : '0;
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: default-size instance plus a 4-register instance.
module tb_reg_dump_sequencer;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_tx_ready = 1'b1;
    logic [31:0] i_reg_data;
    logic        o_br_enable;
    logic [4:0]  o_br_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_busy;
    logic        o_done;

    logic        start4 = 1'b0;
    logic        abort4 = 1'b0;
    logic        ready4 = 1'b1;
    logic [31:0] reg_data4;
    logic        br_en4;
    logic [4:0]  addr4;
    logic [7:0]  data4;
    logic        valid4;
    logic        busy4;
    logic        done4;

    logic [31:0] bank [32];
    assign i_reg_data = bank[o_br_addr];
    assign reg_data4  = bank[addr4];

    reg_dump_sequencer dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_reg_data(i_reg_data), .i_tx_ready(i_tx_ready),
        .o_br_enable(o_br_enable), .o_br_addr(o_br_addr), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_done(o_done)
    );

    reg_dump_sequencer #(.N_REGS(4)) dut4 (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(start4), .i_abort(abort4),
        .i_reg_data(reg_data4), .i_tx_ready(ready4),
        .o_br_enable(br_en4), .o_br_addr(addr4), .o_tx_data(data4),
        .o_tx_valid(valid4), .o_busy(busy4), .o_done(done4)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc = cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int rdy_mode = 0;  // 0: ready high, 1: random ready, 2: driven by hand
    int t0 = 0;
    int t4 = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [4:0] addr_q[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int stalls = 0;

    logic [7:0] got4_q[$];
    int done4_cnt = 0;
    int done4_cyc = -1;
    int max4 = 0;

    always @(negedge i_clock) begin
        if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
        if (o_tx_valid && !i_tx_ready) stalls = stalls + 1;
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - t0;
        end
        if (o_br_enable && (addr_q.size() == 0 || addr_q[$] != o_br_addr)) addr_q.push_back(o_br_addr);
        if (valid4 && ready4) got4_q.push_back(data4);
        if (done4) begin
            done4_cnt = done4_cnt + 1;
            done4_cyc = cyc - t4;
        end
        if (br_en4 && int'(addr4) > max4) max4 = int'(addr4);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk = n_chk + 1;
        assert (obs === expv) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
        if (rdy_mode == 0) i_tx_ready = 1'b1;
        else if (rdy_mode == 1) i_tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_log();
        got_q.delete();
        addr_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        stalls = 0;
    endtask

    // Reference byte stream: every register of the bank, low byte first.
    task automatic build_exp(input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(bank[k] >> (8 * b)));
    endtask

    task automatic check_stream(input string tag, input logic [7:0] q[$]);
        int mism = 0;
        check({tag, "_count"}, 32'(q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < q.size(); i++)
            if (q[i] !== exp_q[i]) mism = mism + 1;
        check({tag, "_bytes"}, 32'(mism), 32'd0);
    endtask

    task automatic start_dump();
        clear_log();
        i_start = 1'b1;
        t0 = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        check("done_seen", 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic fill_bank(input bit rnd);
        for (int k = 0; k < 32; k++) bank[k] = rnd ? $urandom : 32'h1000_0000 + 32'(k);
    endtask

    initial begin
        fill_bank(1'b0);
        #3;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_outs", {o_br_enable, o_tx_valid, o_done, o_br_addr, o_tx_data}, 0);
        #9 i_reset = 1'b0;
        tick();

        // Full dump, with a start pulse landing while busy at reg 3
        rdy_mode = 0;
        start_dump();
        for (int i = 0; i < 100 && o_br_addr != 5'd3; i++) tick();
        check("reach_reg3", 32'(o_br_addr), 32'd3);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_done(400);
        build_exp(32);
        check_stream("full", got_q);
        check("reg5_bytes", {got_q[23], got_q[22], got_q[21], got_q[20]}, 32'h1000_0005);
        check("addr_sweep_len", 32'(addr_q.size()), 32'd32);
        begin
            int bad = 0;
            for (int i = 0; i < addr_q.size(); i++) if (int'(addr_q[i]) != i) bad = bad + 1;
            check("addr_sweep", 32'(bad), 0);
        end
        check("done_cycle", 32'(done_cyc), 32'd225);
        check("done_once", 32'(done_cnt), 32'd1);
        check("busy_after_done", 32'(o_busy), 0);
        check("cycle_after_done", 32'(cyc - t0), 32'd226);

        // Backpressure on byte 1 of reg 0
        bank[0] = 32'hA1B2_C3D4;
        rdy_mode = 2;
        i_tx_ready = 1'b1;
        start_dump();
        tick();
        tick();
        tick();
        i_tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("stall_data", 32'(o_tx_data), 32'h0000_00C3);
            check("stall_valid", 32'(o_tx_valid), 32'd1);
            tick();
        end
        i_tx_ready = 1'b1;
        rdy_mode = 0;
        wait_done(400);
        build_exp(32);
        check_stream("bp", got_q);
        check("bp_stalls", 32'(stalls), 32'd3);
        check("bp_done_cycle", 32'(done_cyc), 32'd228);

        // Random bank and random ready: each stall costs exactly one cycle
        fill_bank(1'b1);
        rdy_mode = 1;
        start_dump();
        wait_done(3000);
        rdy_mode = 0;
        build_exp(32);
        check_stream("rand", got_q);
        check("rand_done_cycle", 32'(done_cyc), 32'(225 + stalls));

        // Abort while reg 10 is sending, then restart from scratch
        start_dump();
        for (int i = 0; i < 200 && !(o_br_addr == 5'd10 && o_tx_valid); i++) tick();
        check("reach_reg10", {o_tx_valid, 27'd0, o_br_addr}, {1'b1, 27'd0, 5'd10});
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_outs", {o_busy, o_br_enable, o_tx_valid, o_done, o_br_addr, o_tx_data}, 0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_done", 32'(done_cnt), 0);
        start_dump();
        check("restart_addr", {o_br_enable, 26'd0, o_br_addr}, {1'b1, 26'd0, 5'd0});
        wait_done(400);
        check_stream("restart", got_q);
        check("restart_done_cycle", 32'(done_cyc), 32'd225);

        // Start and abort together in IDLE
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        check("collide_idle", {o_busy, o_br_enable, o_tx_valid}, 0);
        tick();
        check("collide_idle2", 32'(o_busy), 0);

        // Four-register instance
        got4_q.delete();
        start4 = 1'b1;
        t4 = cyc;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 100 && done4_cnt == 0; i++) tick();
        build_exp(4);
        check_stream("n4", got4_q);
        check("n4_max_addr", 32'(max4), 32'd3);
        check("n4_done_cycle", 32'(done4_cyc), 32'd29);

        // Asynchronous reset between edges while sending
        start_dump();
        for (int i = 0; i < 20 && !o_tx_valid; i++) tick();
        check("pre_reset_send", 32'(o_tx_valid), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        check("async_rst_outs", {o_busy, o_br_enable, o_tx_valid, o_done, o_br_addr, o_tx_data}, 0);
        #10 i_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_idle", {o_busy, o_tx_valid, o_br_enable}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
